// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and
// command/response records used by the master, the slave and benches.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic                  err;
    logic [APB_DATA_W-1:0] rdata;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB3 master: turns valid/ready commands into SETUP/ACCESS transfers and
// returns a one-cycle response. Optional ACCESS timeout: APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslvrr
);

  apb_state_t state, state_nxt;
  logic       accept;
  logic       done;
  logic       tmo;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("apb_master: TIMEOUT must be at least 1");
  end

  assign accept = cmd_valid && cmd_ready;
  assign done   = (state == ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counts pready=0 ACCESS cycles; fires on the edge that would make it TIMEOUT.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == ACCESS) && !pready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo = (state == ACCESS) && !pready && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_nxt = accept ? SETUP : IDLE;
        end else if (tmo) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready follows pready in ACCESS so the next command can chain into SETUP.
  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    cmd_ready = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      SETUP:   psel = 1'b1;
      ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        cmd_ready = pready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_write ? cmd_wdata : '0;
    end
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done || tmo;
      if (done) begin
        rsp_err   <= pslvrr;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (tmo) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule
